// File: rtl/audio_pkg.sv
// Shared types and constants for the audio conditioner datapath.
// Latency: n/a (types only). Backpressure: n/a.
// Holds FSM/mode enums, the rounding-bias helper and the DC blocker pole shift.
package audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SCALE = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    typedef enum logic {
        MODE_MIX = 1'b0,
        MODE_SEL = 1'b1
    } mode_e;

    localparam int DC_SHIFT = 10;

    // Half an output LSB expressed in input-scale units.
    function automatic longint round_bias(input int in_w, input int out_w);
        return longint'(1) << (in_w - out_w - 1);
    endfunction

endpackage

// File: rtl/audio_conditioner_sat_round.sv
// Gain shift, round-half-up, requantise and saturate one sample; flags clipping.
// Latency: purely combinational. Backpressure: none, caller holds inputs stable.
// Computed in a widened word so neither gain nor rounding can wrap before the range check.
module sat_round
    import audio_pkg::*;
#(
    parameter int IN_WIDTH  = 24,
    parameter int OUT_WIDTH = 16
) (
    input  logic signed [IN_WIDTH+1:0]  v_i,
    input  logic        [2:0]           gain_i,
    output logic        [OUT_WIDTH-1:0] sample_o,
    output logic                        clip_o
);

    localparam int VW = IN_WIDTH + 2;
    localparam int SW = VW + 8;
    localparam int D  = IN_WIDTH - OUT_WIDTH;
    localparam logic signed [SW-1:0] ROUND_BIAS = SW'(round_bias(IN_WIDTH, OUT_WIDTH));

    logic signed [SW-1:0] shifted;
    logic signed [SW-1:0] rounded;
    logic signed [SW-1:0] scaled;
    logic                 ovf;
    logic                 sat;

    always_comb begin
        shifted = SW'(v_i) <<< gain_i;
        rounded = shifted + ROUND_BIAS;
        scaled  = rounded >>> D;
        // Gain overflow: shifted value no longer fits the signed input range.
        ovf = !((&shifted[SW-1:IN_WIDTH-1]) || !(|shifted[SW-1:IN_WIDTH-1]));
        sat = !((&scaled[SW-1:OUT_WIDTH-1]) || !(|scaled[SW-1:OUT_WIDTH-1]));
        if (sat) begin
            sample_o = scaled[SW-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                    : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else begin
            sample_o = scaled[OUT_WIDTH-1:0];
        end
        clip_o = sat || ovf;
    end

endmodule

// File: rtl/audio_conditioner.sv
// Captures per-channel samples, mixes or selects a channel, applies gain/round/saturate; AUDIO_COND_DCBLOCK_EN adds a DC blocker.
// Latency: valid_out rises NUM_CH+2 cycles after the frame-complete strobe.
// Backpressure: result held until ready_in; frames completing while busy are dropped and counted.
module audio_conditioner
    import audio_pkg::*;
#(
    parameter int IN_WIDTH  = 24,
    parameter int OUT_WIDTH = 16,
    parameter int NUM_CH    = 2
) (
    input  logic                                           clk_in,
    input  logic                                           rst_in,
    input  logic [IN_WIDTH-1:0]                            sample_in,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_in,
    input  logic                                           valid_in,
    input  logic                                           mode_in,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] sel_in,
    input  logic [2:0]                                     gain_in,
    output logic [OUT_WIDTH-1:0]                           sample_out,
    output logic                                           valid_out,
    input  logic                                           ready_in,
    output logic                                           clip_out,
    output logic [15:0]                                    drop_count_out
);

    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LG = $clog2(NUM_CH);
    localparam int AW = IN_WIDTH + LG;
    localparam int VW = IN_WIDTH + 2;

    state_e                                state_q;
    mode_e                                 mode_q;
    logic [CW-1:0]                         sel_q;
    logic [CW-1:0]                         cnt_q;
    logic [2:0]                            gain_q;
    logic [NUM_CH-1:0][IN_WIDTH-1:0]       cap_q;
    logic [NUM_CH-1:0][IN_WIDTH-1:0]       cap_d;
    logic [NUM_CH-1:0][IN_WIDTH-1:0]       work_q;
    logic signed [AW-1:0]                  acc_q;
    logic signed [AW-1:0]                  acc_shr;
    logic signed [AW-1:0]                  addend;
    logic signed [VW-1:0]                  v_base;
    logic signed [VW-1:0]                  v_cond;
    logic [OUT_WIDTH-1:0]                  sample_q;
    logic [OUT_WIDTH-1:0]                  sr_sample;
    logic                                  sr_clip;
    logic                                  valid_q;
    logic                                  clip_q;
    logic [15:0]                           drop_q;
    logic                                  fc;

    assign fc = valid_in && (ch_in == CW'(NUM_CH - 1));

    always_comb begin
        cap_d = cap_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (valid_in && (ch_in == CW'(i))) cap_d[i] = sample_in;
        end
    end

    always_comb begin
        addend = AW'($signed(work_q[cnt_q]));
        if (mode_q == MODE_SEL && cnt_q != sel_q) addend = '0;
    end

    assign acc_shr = acc_q >>> LG;
    assign v_base  = (mode_q == MODE_MIX) ? VW'($signed(acc_shr[IN_WIDTH-1:0]))
                                          : VW'($signed(acc_q[IN_WIDTH-1:0]));

`ifdef AUDIO_COND_DCBLOCK_EN
    logic signed [VW-1:0] v_prev_q;
    logic signed [VW-1:0] y_prev_q;
    assign v_cond = v_base - v_prev_q + y_prev_q - (y_prev_q >>> DC_SHIFT);
`else
    assign v_cond = v_base;
`endif

    sat_round #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_sat_round (
        .v_i      (v_cond),
        .gain_i   (gain_q),
        .sample_o (sr_sample),
        .clip_o   (sr_clip)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_MIX;
            sel_q    <= '0;
            cnt_q    <= '0;
            gain_q   <= '0;
            cap_q    <= '0;
            work_q   <= '0;
            acc_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            clip_q   <= 1'b0;
            drop_q   <= '0;
`ifdef AUDIO_COND_DCBLOCK_EN
            v_prev_q <= '0;
            y_prev_q <= '0;
`endif
        end else begin
            cap_q <= cap_d;
            // Any frame completing outside IDLE, including the HOLD handshake cycle, is lost.
            if (fc && state_q != ST_IDLE && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            case (state_q)
                ST_IDLE: begin
                    if (fc) begin
                        work_q  <= cap_d;
                        mode_q  <= mode_e'(mode_in);
                        sel_q   <= sel_in;
                        gain_q  <= gain_in;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    acc_q <= acc_q + addend;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(NUM_CH - 1)) state_q <= ST_SCALE;
                end
                ST_SCALE: begin
                    sample_q <= sr_sample;
                    clip_q   <= sr_clip;
                    valid_q  <= 1'b1;
                    state_q  <= ST_HOLD;
`ifdef AUDIO_COND_DCBLOCK_EN
                    v_prev_q <= v_base;
                    y_prev_q <= v_cond;
`endif
                end
                ST_HOLD: begin
                    if (ready_in) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sample_out     = sample_q;
    assign valid_out      = valid_q;
    assign clip_out       = clip_q;
    assign drop_count_out = drop_q;

endmodule

// File: doc/audio_conditioner.md
AUDIO_CONDITIONER -- requirements
Module: audio_conditioner

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 24: signed input sample width.
REQ-002 SHALL have parameter OUT_WIDTH, default 16: signed output sample width, less than IN_WIDTH.
REQ-003 SHALL have parameter NUM_CH, default 2: channels per frame, a power of two, at least 1.
REQ-004 SHALL have port clk_in, input, 1 bit: single clock.
REQ-005 SHALL have port rst_in, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port sample_in, input, IN_WIDTH bits: signed channel sample.
REQ-007 SHALL have port ch_in, input, max(1,$clog2(NUM_CH)) bits: channel index of sample_in.
REQ-008 SHALL have port valid_in, input, 1 bit: one-cycle strobe qualifying sample_in/ch_in.
REQ-009 SHALL have port mode_in, input, 1 bit: 0 = mono mix, 1 = single-channel select.
REQ-010 SHALL have port sel_in, input, same width as ch_in: channel used when mode_in = 1.
REQ-011 SHALL have port gain_in, input, 3 bits: left-shift gain 0..7.
REQ-012 SHALL have port sample_out, output, OUT_WIDTH bits: conditioned signed sample.
REQ-013 SHALL have port valid_out, output, 1 bit: sample_out holds a valid sample.
REQ-014 SHALL have port ready_in, input, 1 bit: consumer accepts when valid_out and ready_in are both high.
REQ-015 SHALL have port clip_out, output, 1 bit: the held sample was saturated.
REQ-016 SHALL have port drop_count_out, output, 16 bits: saturating count of dropped frames.

Function
REQ-017 SHALL store sample_in into capture register [ch_in] on each valid_in.
- Channels missing from a frame keep their previous value.
REQ-018 SHALL treat a valid_in with ch_in = NUM_CH-1 as frame complete (FC).
REQ-019 SHALL implement states IDLE, ACCUM, SCALE and HOLD.
REQ-020 SHALL handle FC in IDLE as follows:
- snapshot all capture registers, including the sample arriving that cycle, into work registers;
- latch mode_in, sel_in and gain_in;
- enter ACCUM.
REQ-021 SHALL, in ACCUM, add one work register per cycle to an IN_WIDTH+$clog2(NUM_CH)-bit signed accumulator.
- ACCUM lasts NUM_CH cycles, then the FSM enters SCALE.
- In select mode, only work register [sel] is added; all others contribute zero.
REQ-022 SHALL, in SCALE, form the value v as follows:
- mix mode: accumulator arithmetic-shifted right by $clog2(NUM_CH);
- select mode: accumulator unshifted.
REQ-023 SHALL then compute, from v:
- shift v left by gain;
- add 2^(IN_WIDTH-OUT_WIDTH-1) for round-half-up;
- arithmetic-shift right by IN_WIDTH-OUT_WIDTH;
- saturate to the signed OUT_WIDTH range.
REQ-024 SHALL set clip_out when saturation or gain-shift overflow occurred, otherwise clear it.
REQ-025 SHALL register the REQ-023 result into sample_out, assert valid_out and enter HOLD.
- Latency: valid_out rises NUM_CH+2 cycles after the FC cycle.
REQ-026 SHALL, in HOLD, keep sample_out, clip_out and valid_out stable until ready_in is high, then deassert valid_out and enter IDLE on the next cycle.
REQ-027 SHALL, for an FC outside IDLE, drop the frame and increment drop_count_out, saturating at 16'hFFFF.
- Capture registers still update.
REQ-028 SHALL act on an FC arriving in the same cycle the HOLD handshake completes as a drop, not as a start.

Reset
REQ-029 SHALL, while rst_in is low, asynchronously force:
- FSM to IDLE;
- capture, work and accumulator registers to 0;
- sample_out to 0, valid_out to 0, clip_out to 0, drop_count_out to 0.
REQ-030 SHALL, on reset mid-frame or mid-HOLD, discard the in-flight sample with no valid_out pulse.

Configuration
REQ-031 SHALL, when AUDIO_COND_DCBLOCK_EN is defined, apply a DC blocker to v in SCALE before the gain shift.
- y = v - v_prev + y_prev - (y_prev >>> 10).
- v_prev and y_prev are IN_WIDTH+2-bit registers, reset to 0, updated once per emitted frame.
REQ-032 SHALL, without AUDIO_COND_DCBLOCK_EN, pass v unchanged and contain no blocker state.

Structure
REQ-033 SHALL import from package audio_pkg:
- state enum type;
- mode enum type;
- localparam ROUND_BIAS helper;
- DC_SHIFT = 10.
REQ-034 SHALL place shift/round/saturate/clip-detect in one combinational sub-module, sat_round.

Verification
Defaults: IN_WIDTH 24, OUT_WIDTH 16, NUM_CH 2, gain 0.
REQ-035 SHALL check mix mode: ch0 = 24'h100000, ch1 = 24'h300000, ready_in high -> sample_out 16'h2000, clip_out 0, valid_out high 4 cycles after ch1 strobe.
REQ-036 SHALL check select mode with sel = 1 on the same frame -> 16'h3000.
REQ-037 SHALL check rounding and saturation in mix mode:
- both channels 24'hFFFF00 -> 16'hFFFF;
- both 24'h7FFF80 -> 16'h7FFF, clip_out 1;
- both 24'h500000 at gain 1 -> 16'h7FFF, clip_out 1.
REQ-038 SHALL check backpressure: ready_in low, three further frames -> sample_out stable, drop_count_out = 3; ready_in high -> valid_out low next cycle.
REQ-039 SHALL check reset: rst_in low during ACCUM -> all outputs 0 immediately, no valid_out after release.
REQ-040 SHALL check DC blocker (AUDIO_COND_DCBLOCK_EN defined): 200 frames of constant 24'h100000 -> sample_out decays monotonically toward 0 from 16'h1000.
